regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_pkg.sv | 28 ++
 rtl/regfile_rd_port.sv | 47 ++++
 rtl/regfile_mp.sv | 107 ++++++++++
 tb/tb_regfile_mp.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// ============================================================
// regfile_pkg : default sizing and write-port arbitration
// Rev 1.0
// ============================================================
`default_nettype none

package regfile_pkg;

  localparam int c_DATA_W   = 16;
  localparam int c_ADDR_W   = 3;
  localparam int c_NRD      = 2;
  localparam int c_NWR      = 1;
  localparam int c_MAX_NWR  = 2;

  // Index of the write port that owns a register when several hit it;
  // the highest-index hitting port wins.
  function automatic int unsigned wr_winner(input logic [c_MAX_NWR-1:0] hit);
    int unsigned idx;
    idx = 0;
    for (int w = 0; w < c_MAX_NWR; w++) begin
      if (hit[w]) idx = w;
    end
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_rd_port.sv
// ============================================================
// regfile_rd_port : one registered read port (data + busy sample)
// Rev 1.0
// ============================================================
`default_nettype none

module regfile_rd_port #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int NREG   = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_rd_en,
  input  logic [ADDR_W-1:0]      i_rd_addr,
  input  logic [NREG*DATA_W-1:0] i_src_data,
  input  logic [NREG-1:0]        i_src_busy,
  output logic [DATA_W-1:0]      o_rd_data,
  output logic                   o_rd_valid,
  output logic                   o_rd_busy
);

  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_valid <= i_rd_en;
      if (i_rd_en) begin
        r_data <= i_src_data[i_rd_addr*DATA_W +: DATA_W];
        r_busy <= i_src_busy[i_rd_addr];
      end
    end
  end

  assign o_rd_data  = r_data;
  assign o_rd_valid = r_valid;
  assign o_rd_busy  = r_busy;

endmodule

`default_nettype wire

// File: rtl/regfile_mp.sv
// ============================================================
// regfile_mp : multi-port register file with busy scoreboard
// Rev 1.0
// ============================================================
`default_nettype none

module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = c_DATA_W,
  parameter int ADDR_W   = c_ADDR_W,
  parameter int NRD      = c_NRD,
  parameter int NWR      = c_NWR,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NRD-1:0]        rd_en,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_valid,
  output logic [NRD-1:0]        rd_busy,
  input  logic [NWR-1:0]        wr_en,
  input  logic [NWR*ADDR_W-1:0] wr_addr,
  input  logic [NWR*DATA_W-1:0] wr_data,
  input  logic                  rsv_en,
  input  logic [ADDR_W-1:0]     rsv_addr,
  output logic [(2**ADDR_W)-1:0] busy
);

  localparam int NREG = 2**ADDR_W;

  logic [NREG*DATA_W-1:0] w_cur_data;
  logic [NREG*DATA_W-1:0] w_next_data;
  logic [NREG-1:0]        w_cur_busy;
  logic [NREG-1:0]        w_next_busy;
  logic [NREG*DATA_W-1:0] w_src_data;
  logic [NREG-1:0]        w_src_busy;

  for (genvar i = 0; i < NREG; i++) begin : g_reg
    localparam bit c_HARD_ZERO = (ZERO_REG != 0) && (i == 0);

    logic [DATA_W-1:0]    r_q;
    logic                 r_bsy;
    logic [c_MAX_NWR-1:0] w_hit;
    logic                 w_rsv;
    logic [DATA_W-1:0]    w_wdata;
    logic [DATA_W-1:0]    w_nxt_q;
    logic                 w_nxt_bsy;

    always_comb begin
      w_hit = '0;
      for (int w = 0; w < NWR; w++) begin
        w_hit[w] = wr_en[w] && (wr_addr[w*ADDR_W +: ADDR_W] == ADDR_W'(i));
      end
      if (c_HARD_ZERO) w_hit = '0;
      w_rsv   = rsv_en && (rsv_addr == ADDR_W'(i)) && !c_HARD_ZERO;
      w_wdata = wr_data[wr_winner(w_hit)*DATA_W +: DATA_W];
      w_nxt_q = (|w_hit) ? w_wdata : r_q;
      // A same-edge reservation belongs to a newer producer, so it beats the write's clear.
      if (w_rsv)       w_nxt_bsy = 1'b1;
      else if (|w_hit) w_nxt_bsy = 1'b0;
      else             w_nxt_bsy = r_bsy;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_q   <= '0;
        r_bsy <= 1'b0;
      end else begin
        r_q   <= w_nxt_q;
        r_bsy <= w_nxt_bsy;
      end
    end

    assign w_cur_data[i*DATA_W +: DATA_W]  = r_q;
    assign w_next_data[i*DATA_W +: DATA_W] = w_nxt_q;
    assign w_cur_busy[i]                   = r_bsy;
    assign w_next_busy[i]                  = w_nxt_bsy;
  end

  assign w_src_data = (BYPASS != 0) ? w_next_data : w_cur_data;
  assign w_src_busy = (BYPASS != 0) ? w_next_busy : w_cur_busy;
  assign busy       = w_cur_busy;

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    regfile_rd_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .NREG   (NREG)
    ) u_rd_port (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_rd_en    (rd_en[p]),
      .i_rd_addr  (rd_addr[p*ADDR_W +: ADDR_W]),
      .i_src_data (w_src_data),
      .i_src_busy (w_src_busy),
      .o_rd_data  (rd_data[p*DATA_W +: DATA_W]),
      .o_rd_valid (rd_valid[p]),
      .o_rd_busy  (rd_busy[p])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
// ============================================================
// tb_regfile_mp : directed bench, bypass and non-bypass instances
// Rev 1.0
// ============================================================
`default_nettype none

module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  rd_en;
  logic [5:0]  rd_addr;
  logic [1:0]  wr_en;
  logic [5:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rsv_en;
  logic [2:0]  rsv_addr;

  logic [31:0] a_rd_data,  b_rd_data;
  logic [1:0]  a_rd_valid, b_rd_valid;
  logic [1:0]  a_rd_busy,  b_rd_busy;
  logic [7:0]  a_busy,     b_busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(16), .ADDR_W(3), .NRD(2), .NWR(2), .ZERO_REG(1), .BYPASS(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(a_rd_data),
    .rd_valid(a_rd_valid), .rd_busy(a_rd_busy), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy(a_busy)
  );

  regfile_mp #(.DATA_W(16), .ADDR_W(3), .NRD(2), .NWR(2), .ZERO_REG(1), .BYPASS(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(b_rd_data),
    .rd_valid(b_rd_valid), .rd_busy(b_rd_busy), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy(b_busy)
  );

  task automatic idle();
    rd_en = '0; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
    rsv_en = 1'b0; rsv_addr = '0;
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if (a_rd_data !== 32'h0 || a_rd_valid !== 2'b00 || a_rd_busy !== 2'b00) begin
      failures++;
      $display("FAIL reset_outputs actual=%h/%b/%b required=0/00/00", a_rd_data, a_rd_valid, a_rd_busy);
    end
    checks++;
    if (a_busy !== 8'h00) begin
      failures++; $display("FAIL reset_busy actual=%h required=00", a_busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    rd_en = 2'b01; rd_addr = {3'd0, 3'd3};
    edge_sample();
    checks++;
    if (a_rd_valid !== 2'b01 || a_rd_data[15:0] !== 16'h0000) begin
      failures++;
      $display("FAIL reset_read_r3 actual=%b/%h required=01/0000", a_rd_valid, a_rd_data[15:0]);
    end
    @(negedge clk);
    idle();
    edge_sample();
    checks++;
    if (a_rd_valid !== 2'b00) begin
      failures++; $display("FAIL valid_drop actual=%b required=00", a_rd_valid);
    end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    idle();
    wr_en = 2'b01; wr_addr = {3'd0, 3'd2}; wr_data = {16'h0, 16'h00AA};
    rd_en = 2'b01; rd_addr = {3'd0, 3'd2};
    edge_sample();
    checks++;
    if (a_rd_data[15:0] !== 16'h00AA) begin
      failures++; $display("FAIL bypass_on actual=%h required=00aa", a_rd_data[15:0]);
    end
    checks++;
    if (b_rd_data[15:0] !== 16'h0000) begin
      failures++; $display("FAIL bypass_off actual=%h required=0000", b_rd_data[15:0]);
    end
    @(negedge clk);
    idle();
    rd_en = 2'b01; rd_addr = {3'd0, 3'd2};
    edge_sample();
    checks++;
    if (b_rd_data[15:0] !== 16'h00AA) begin
      failures++; $display("FAIL bypass_off_next actual=%h required=00aa", b_rd_data[15:0]);
    end
  endtask

  task automatic test_hold();
    @(negedge clk);
    idle();
    rd_addr = {3'd5, 3'd5};
    edge_sample();
    checks++;
    if (a_rd_data[15:0] !== 16'h00AA || a_rd_valid !== 2'b00) begin
      failures++;
      $display("FAIL hold actual=%h/%b required=00aa/00", a_rd_data[15:0], a_rd_valid);
    end
  endtask

  task automatic test_write_priority();
    @(negedge clk);
    idle();
    wr_en = 2'b11; wr_addr = {3'd5, 3'd5}; wr_data = {16'h2222, 16'h1111};
    edge_sample();
    @(negedge clk);
    idle();
    rd_en = 2'b11; rd_addr = {3'd5, 3'd5};
    edge_sample();
    checks++;
    if (a_rd_data !== 32'h2222_2222) begin
      failures++; $display("FAIL wr_priority_a actual=%h required=22222222", a_rd_data);
    end
    checks++;
    if (b_rd_data !== 32'h2222_2222 || b_rd_valid !== 2'b11) begin
      failures++; $display("FAIL wr_priority_b actual=%h/%b required=22222222/11", b_rd_data, b_rd_valid);
    end
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    idle();
    wr_en = 2'b01; wr_addr = {3'd0, 3'd0}; wr_data = {16'h0, 16'hFFFF};
    rsv_en = 1'b1; rsv_addr = 3'd0;
    rd_en = 2'b10; rd_addr = {3'd0, 3'd0};
    edge_sample();
    checks++;
    if (a_rd_data[31:16] !== 16'h0000 || a_rd_busy[1] !== 1'b0) begin
      failures++;
      $display("FAIL zero_bypass actual=%h/%b required=0000/0", a_rd_data[31:16], a_rd_busy[1]);
    end
    @(negedge clk);
    idle();
    rd_en = 2'b01; rd_addr = {3'd0, 3'd0};
    edge_sample();
    checks++;
    if (a_rd_data[15:0] !== 16'h0000 || b_rd_data[15:0] !== 16'h0000 || a_busy[0] !== 1'b0) begin
      failures++;
      $display("FAIL zero_reg actual=%h/%h/%b required=0000/0000/0", a_rd_data[15:0], b_rd_data[15:0], a_busy[0]);
    end
  endtask

  task automatic test_scoreboard();
    @(negedge clk);
    idle();
    rsv_en = 1'b1; rsv_addr = 3'd4;
    rd_en = 2'b01; rd_addr = {3'd0, 3'd4};
    edge_sample();
    checks++;
    if (a_busy !== 8'h10 || b_busy !== 8'h10) begin
      failures++; $display("FAIL rsv_set actual=%h/%h required=10/10", a_busy, b_busy);
    end
    checks++;
    if (a_rd_busy[0] !== 1'b1 || b_rd_busy[0] !== 1'b0) begin
      failures++; $display("FAIL rd_busy_edge actual=%b/%b required=1/0", a_rd_busy[0], b_rd_busy[0]);
    end
    @(negedge clk);
    idle();
    rsv_en = 1'b1; rsv_addr = 3'd4;
    edge_sample();
    checks++;
    if (a_busy !== 8'h10) begin
      failures++; $display("FAIL rsv_again actual=%h required=10", a_busy);
    end
    @(negedge clk);
    idle();
    wr_en = 2'b01; wr_addr = {3'd0, 3'd4}; wr_data = {16'h0, 16'h0042};
    edge_sample();
    checks++;
    if (a_busy !== 8'h00) begin
      failures++; $display("FAIL wr_clears actual=%h required=00", a_busy);
    end
    @(negedge clk);
    idle();
    wr_en = 2'b10; wr_addr = {3'd4, 3'd0}; wr_data = {16'h0042, 16'h0};
    rsv_en = 1'b1; rsv_addr = 3'd4;
    edge_sample();
    checks++;
    if (a_busy !== 8'h10) begin
      failures++; $display("FAIL rsv_wr_same actual=%h required=10", a_busy);
    end
    @(negedge clk);
    idle();
    rd_en = 2'b10; rd_addr = {3'd4, 3'd0};
    edge_sample();
    checks++;
    if (a_rd_data[31:16] !== 16'h0042 || a_rd_busy[1] !== 1'b1) begin
      failures++;
      $display("FAIL rsv_wr_read actual=%h/%b required=0042/1", a_rd_data[31:16], a_rd_busy[1]);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    idle();
    wr_en = 2'b01; wr_addr = {3'd0, 3'd1}; wr_data = {16'h0, 16'h1234};
    rsv_en = 1'b1; rsv_addr = 3'd6;
    edge_sample();
    @(negedge clk);
    idle();
    rd_en = 2'b01; rd_addr = {3'd0, 3'd1};
    edge_sample();
    checks++;
    if (a_rd_data[15:0] !== 16'h1234) begin
      failures++; $display("FAIL pre_reset_read actual=%h required=1234", a_rd_data[15:0]);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (a_rd_data !== 32'h0 || a_busy !== 8'h00 || a_rd_busy !== 2'b00 || a_rd_valid !== 2'b00) begin
      failures++;
      $display("FAIL async_reset actual=%h/%h/%b/%b required=0/00/00/00", a_rd_data, a_busy, a_rd_busy, a_rd_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    rd_en = 2'b01; rd_addr = {3'd0, 3'd1};
    edge_sample();
    checks++;
    if (a_rd_data[15:0] !== 16'h0000 || a_rd_valid !== 2'b01) begin
      failures++;
      $display("FAIL post_reset_read actual=%h/%b required=0000/01", a_rd_data[15:0], a_rd_valid);
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_hold();
    test_write_priority();
    test_zero_reg();
    test_scoreboard();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
